lfsr_pattern_checker: RTL
=========================

Name: lfsr_pattern_checker

Overview:
Receive-side BIST checker for the UART loopback path. It consumes bytes delivered by the UART receiver and compares them against a local replica of the transmit-side 16-bit Fibonacci LFSR byte stream. Feedback is bit WIDTH-1 ^ bit 6 ^ bit 4 ^ bit 3, shifted in at bit 0; the byte is state[7:0]; the state steps one bit per byte. The checker aligns on the seed byte, counts mismatches over a fixed-length run, and reports pass/fail to the BIST controller.

Parameters:
WIDTH, 16, LFSR state width; must match the transmit generator.
SEED, 16'hACE1, LFSR seed; SEED[7:0] is the alignment byte.
NUM_BYTES, 256, bytes per run, alignment byte included; range 1..2^CNT_W-1.
HUNT_MAX, 16, consecutive non-seed bytes tolerated in HUNT before failing.
CNT_W, 16, width of the byte and error counters.

Ports:
i_Clock  in  1  clock; all logic on posedge.
i_Reset  in  1  synchronous, active-high reset.
i_Start  in  1  one-cycle pulse that (re)starts a run from any state.
i_Rx_DV  in  1  received byte valid; one-cycle pulse per byte.
i_Rx_Byte  in  8  received byte; sampled only when i_Rx_DV=1.
o_Busy  out  1  1 in HUNT or CHECK.
o_Locked  out  1  alignment byte found in the current run.
o_Done  out  1  run finished; held until the next i_Start or reset.
o_Pass  out  1  valid only while o_Done=1; 1 = locked and zero errors.
o_Error_Pulse  out  1  one-cycle pulse per mismatching byte.
o_Error_Count  out  CNT_W  mismatch count; saturates at all-ones.
o_Byte_Count  out  CNT_W  bytes checked in the current run.

Behaviour:
- Reset: state IDLE, replica LFSR = SEED, hunt counter 0, all outputs 0.
- All outputs are registered. Each response appears on the cycle after the i_Rx_DV or i_Start sample.
- i_Start in any state:
  - clears all counters, o_Locked, o_Done, o_Pass and o_Error_Pulse;
  - reloads the LFSR with SEED;
  - moves to HUNT.
  - If i_Start and i_Rx_DV coincide, i_Start wins and the byte is dropped.
- IDLE: i_Rx_DV is ignored.
- HUNT, on each i_Rx_DV:
  - i_Rx_Byte == SEED[7:0]: the byte counts as checked (o_Byte_Count=1), the LFSR steps once, o_Locked=1, go to CHECK. If NUM_BYTES==1, go to DONE with pass instead.
  - Otherwise: discard the byte and increment the hunt counter. On reaching HUNT_MAX, go to DONE with o_Pass=0 and o_Locked=0.
- CHECK, on each i_Rx_DV:
  - compare i_Rx_Byte with LFSR[7:0];
  - on mismatch, pulse o_Error_Pulse and increment o_Error_Count (saturating);
  - the LFSR always steps once (no resync after errors);
  - o_Byte_Count increments.
  - When o_Byte_Count reaches NUM_BYTES, go to DONE.
- DONE:
  - o_Done=1 and o_Pass = (o_Error_Count==0) and o_Locked, both asserted the cycle after the last byte;
  - i_Rx_DV is ignored; counts are frozen.
- The LFSR steps only on an accepted, counted byte. It never steps on idle cycles or on discarded HUNT bytes.
- Back-to-back i_Rx_DV on consecutive cycles is supported at full rate.
- i_Reset asserted mid-run aborts the run immediately to the reset state; no o_Done is produced.

Decomposition:
- Shared package lfsr_bist_pkg:
  - state enum (IDLE, HUNT, CHECK, DONE);
  - tap-position constants (6, 4, 3);
  - default seed 16'hACE1;
  - next-state function, shared with the transmit-side generator.
- Sub-module lfsr_ref_gen: replica LFSR with load (to SEED) and step inputs, exposing state[7:0].
- FSM, counters and compare logic stay in the top.

Test Plan:
1. Reset; Start; feed E1, C2, 85, 0B with NUM_BYTES=4 -> o_Done=1 and o_Pass=1 the cycle after the last DV; o_Error_Count=0; o_Byte_Count=4.
2. Start; feed 00, FF, then E1, C2, 85, 0B (NUM_BYTES=4) -> o_Locked rises the cycle after E1; o_Byte_Count=4; o_Pass=1.
3. Start; feed E1, C2, 84, 0B -> exactly one o_Error_Pulse, the cycle after 84; o_Error_Count=1; o_Done=1 with o_Pass=0; o_Locked stays 1.
4. Start; feed 16 bytes of 00 (HUNT_MAX=16) -> o_Done=1, o_Pass=0, o_Locked=0, o_Byte_Count=0.
5. Start; feed E1, C2; then Start coinciding with DV of 85 -> counters cleared, state HUNT, 85 dropped; subsequent E1, C2, 85, 0B -> pass.
6. Start; feed E1 then assert i_Reset -> all outputs 0 next cycle, state IDLE; following DVs ignored until Start.

Source files
------------

// File: rtl/lfsr_bist_pkg.sv
// Shared definitions for the UART loopback BIST: FSM encodings, LFSR taps,
// default seed and the LFSR next-state function used by both TX and RX sides.
package lfsr_bist_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HUNT  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int TAP_A = 6;
    localparam int TAP_B = 4;
    localparam int TAP_C = 3;

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
    localparam int          LFSR_MAX_W   = 32;

    // Fibonacci step: feedback = msb ^ tap6 ^ tap4 ^ tap3, shifted in at bit 0.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] msb_shift_s;
        logic [LFSR_MAX_W-1:0] mask_s;
        logic                  fb_s;
        msb_shift_s = state >> (width - 1);
        fb_s        = msb_shift_s[0] ^ state[TAP_A] ^ state[TAP_B] ^ state[TAP_C];
        if (width >= LFSR_MAX_W) begin
            mask_s = {LFSR_MAX_W{1'b1}};
        end else begin
            mask_s = (32'd1 << width) - 32'd1;
        end
        return {state[LFSR_MAX_W-2:0], fb_s} & mask_s;
    endfunction

endpackage

// File: rtl/lfsr_ref_gen.sv
// Receive-side replica of the transmit LFSR; load returns it to SEED,
// step advances it by one bit (one byte of the stream).
module lfsr_ref_gen
    import lfsr_bist_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEFAULT)
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Load,
    input  logic       i_Step,
    output logic [7:0] o_Byte
);

    logic [WIDTH-1:0] lfsr_r;

    // LFSR state register: load has priority over step.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            lfsr_r <= SEED;
        end else if (i_Load) begin
            lfsr_r <= SEED;
        end else if (i_Step) begin
            lfsr_r <= WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_r), WIDTH));
        end
    end

    assign o_Byte = lfsr_r[7:0];

endmodule

// File: rtl/lfsr_pattern_checker.sv
// UART loopback BIST checker: aligns on the seed byte, then compares each
// received byte against the replica LFSR stream and reports pass/fail.
module lfsr_pattern_checker
    import lfsr_bist_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(SEED_DEFAULT),
    parameter int               NUM_BYTES = 256,
    parameter int               HUNT_MAX  = 16,
    parameter int               CNT_W     = 16
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic             i_Rx_DV,
    input  logic [7:0]       i_Rx_Byte,
    output logic             o_Busy,
    output logic             o_Locked,
    output logic             o_Done,
    output logic             o_Pass,
    output logic             o_Error_Pulse,
    output logic [CNT_W-1:0] o_Error_Count,
    output logic [CNT_W-1:0] o_Byte_Count
);

    localparam int               HUNT_W      = $clog2(HUNT_MAX + 1);
    localparam logic [HUNT_W-1:0] HUNT_LAST  = HUNT_W'(HUNT_MAX - 1);
    localparam logic [CNT_W-1:0] NUM_BYTES_C = CNT_W'(NUM_BYTES);
    localparam logic [7:0]       SEED_BYTE   = SEED[7:0];

    logic [1:0]        state_r;
    logic [HUNT_W-1:0] hunt_cnt_r;
    logic              busy_r;
    logic              locked_r;
    logic              done_r;
    logic              pass_r;
    logic              err_pulse_r;
    logic [CNT_W-1:0]  err_cnt_r;
    logic [CNT_W-1:0]  byte_cnt_r;

    logic [7:0]        ref_byte_s;
    logic              step_s;
    logic              mismatch_s;
    logic [CNT_W-1:0]  err_next_s;

    lfsr_ref_gen #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_ref_gen (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Load  (i_Start),
        .i_Step  (step_s),
        .o_Byte  (ref_byte_s)
    );

    // Step decision and saturating error-count preview for the current byte.
    always_comb begin
        step_s     = 1'b0;
        mismatch_s = (i_Rx_Byte != ref_byte_s);
        err_next_s = err_cnt_r;
        if (i_Rx_DV && !i_Start) begin
            if (state_r == ST_CHECK) begin
                step_s = 1'b1;
            end else if (state_r == ST_HUNT) begin
                step_s = (i_Rx_Byte == SEED_BYTE);
            end else begin
                step_s = 1'b0;
            end
        end else begin
            step_s = 1'b0;
        end
        if (mismatch_s && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_next_s = err_cnt_r + CNT_W'(1);
        end else begin
            err_next_s = err_cnt_r;
        end
    end

    // Run FSM with counters; every output is a register updated here.
    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Start) begin
            state_r     <= i_Reset ? ST_IDLE : ST_HUNT;
            busy_r      <= ~i_Reset;
            hunt_cnt_r  <= {HUNT_W{1'b0}};
            locked_r    <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_pulse_r <= 1'b0;
            err_cnt_r   <= {CNT_W{1'b0}};
            byte_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            err_pulse_r <= 1'b0;
            case (state_r)
                ST_HUNT: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == SEED_BYTE) begin
                            byte_cnt_r <= CNT_W'(1);
                            locked_r   <= 1'b1;
                            if (NUM_BYTES_C == CNT_W'(1)) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                pass_r  <= 1'b1;
                            end else begin
                                state_r <= ST_CHECK;
                            end
                        end else begin
                            hunt_cnt_r <= hunt_cnt_r + HUNT_W'(1);
                            if (hunt_cnt_r == HUNT_LAST) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                pass_r  <= 1'b0;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (i_Rx_DV) begin
                        byte_cnt_r  <= byte_cnt_r + CNT_W'(1);
                        err_cnt_r   <= err_next_s;
                        err_pulse_r <= mismatch_s;
                        if ((byte_cnt_r + CNT_W'(1)) == NUM_BYTES_C) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= locked_r && (err_next_s == {CNT_W{1'b0}});
                        end
                    end
                end
                default: begin
                    state_r <= state_r;
                end
            endcase
        end
    end

    assign o_Busy        = busy_r;
    assign o_Locked      = locked_r;
    assign o_Done        = done_r;
    assign o_Pass        = pass_r;
    assign o_Error_Pulse = err_pulse_r;
    assign o_Error_Count = err_cnt_r;
    assign o_Byte_Count  = byte_cnt_r;

endmodule
